rpn_token_sender: RTL and testbench
===================================

RPN_TOKEN_SENDER -- requirements
Module: rpn_token_sender

Interface
REQ-001 Parameter: DEPTH, 8, token FIFO depth (power of two, at least 2).
REQ-002 Parameter: ACK_TIMEOUT, 255, cycles input_stb may wait for input_ack before abort.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: tok_valid  in  1  user token offered.
REQ-006 Port: tok_data  in  4  operand value or operator code.
REQ-007 Port: tok_is_op  in  1  1 = tok_data is an operator.
REQ-008 Port: tok_ready  out  1  FIFO can accept a token this cycle.
REQ-009 Port: input_stb  out  1  token strobe to calculator.
REQ-010 Port: input_data  out  4  token value to calculator.
REQ-011 Port: is_input_operator  out  1  token kind to calculator.
REQ-012 Port: input_ack  in  1  calculator token acknowledge.
REQ-013 Port: output_stb  in  1  calculator result strobe.
REQ-014 Port: output_data  in  4  calculator result value.
REQ-015 Port: output_ack  out  1  result acknowledge to calculator.
REQ-016 Port: result_valid  out  1  one-cycle pulse when a result is captured.
REQ-017 Port: result_data  out  4  last captured result, held until the next capture.
REQ-018 Port: fifo_count  out  $clog2(DEPTH+1)  tokens currently buffered.
REQ-019 Port: timeout_err  out  1  sticky ack-timeout flag.
REQ-020 Port: clr_err  in  1  synchronous clear of timeout_err.

Function
REQ-021 Push SHALL occur on a rising edge with tok_valid && tok_ready; tok_ready SHALL be 1 exactly when fifo_count < DEPTH (combinational from registered count); tokens offered while full are not taken.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-023 TX FSM states: T_IDLE, T_SEND, T_GAP; it SHALL leave T_IDLE when the FIFO is non-empty, popping the head into the output registers and setting input_stb on the same edge.
REQ-024 Latency: a token pushed at edge E into an empty FIFO with the FSM in T_IDLE SHALL show input_stb=1 after edge E+1.
REQ-025 input_data and is_input_operator SHALL be stable for the whole time input_stb=1.
REQ-026 In T_SEND, when input_ack=1 is sampled, the FSM SHALL clear input_stb and go to T_GAP on that edge.
REQ-027 In T_SEND, after ACK_TIMEOUT cycles without input_ack, the FSM SHALL clear input_stb, discard the token, set timeout_err, and go to T_GAP.
REQ-028 In T_GAP, the FSM SHALL return to T_IDLE on the first edge that samples input_ack=0 (four-phase; at least one idle cycle between tokens).
REQ-029 RX FSM states: R_WAIT, R_HOLD.
REQ-030 In R_WAIT, sampling output_stb=1 SHALL set output_ack, capture output_data into result_data, pulse result_valid for one cycle, and go to R_HOLD.
REQ-031 In R_HOLD, output_ack SHALL stay 1 until output_stb=0 is sampled, then clear and return to R_WAIT.
REQ-032 TX and RX FSMs SHALL run independently; a result handshake during a token handshake SHALL affect neither.
REQ-033 When clr_err and a new timeout occur on the same edge, timeout_err SHALL be 1 (set wins).

Reset
REQ-034 While rst=0, the block SHALL force input_stb=0, output_ack=0, result_valid=0, result_data=0, input_data=0, is_input_operator=0, fifo_count=0, timeout_err=0, TX FSM = T_IDLE, RX FSM = R_WAIT, without waiting for a clock edge.
REQ-035 Reset mid-handshake SHALL drop the in-flight token and all buffered tokens; no token SHALL be replayed after release.

Structure
REQ-036 Shared package rpn_pkg SHALL hold the TX/RX state enums, token struct {is_op, data[3:0]}, and operator code constants (OP_ADD=4'h0, OP_SUB=4'h1, OP_MUL=4'h2, OP_AND=4'h3).
REQ-037 The FIFO SHALL be one sub-module, rpn_token_fifo, parameterised by DEPTH; the FSMs and timeout counter stay in rpn_token_sender.

Verification
REQ-038 Push operand 3, operand 4, and OP_ADD back-to-back; ack each token after 2 cycles -> input_data sequence 3, 4, 0 with is_input_operator 0, 0, 1; input_stb low for at least 1 cycle between tokens.
REQ-039 Hold input_ack=0 and push 9 tokens with DEPTH=8 -> tok_ready=0 after 8 tokens are buffered; the 9th token is not taken; fifo_count never exceeds 8.
REQ-040 Never ack; use ACK_TIMEOUT=4 -> input_stb falls after 4 cycles, timeout_err=1, next token presented; clr_err clears the flag.
REQ-041 Drive output_stb=1 with output_data=7 during an active token handshake -> output_ack=1 on the next edge, result_valid pulses once, result_data=7, output_ack falls after output_stb falls, token handshake unaffected.
REQ-042 Assert rst=0 while input_stb=1 and 3 tokens are queued -> input_stb falls immediately, fifo_count=0 after release, and no token is sent until a new push.

Source files
------------

// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_pkg
// Description : Shared types for the RPN token sender. Holds the TX/RX state
//               encodings, the buffered token layout and the operator codes
//               understood by the downstream RPN calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

  // Token handshake side: idle, strobing a token, waiting for ack release.
  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_SEND = 2'd1,
    T_GAP  = 2'd2
  } tx_state_e;

  // Result handshake side: waiting for a result, holding the acknowledge.
  typedef enum logic [0:0] {
    R_WAIT = 1'b0,
    R_HOLD = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       is_op;
    logic [3:0] data;
  } token_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;

endpackage
`default_nettype wire

// File: rtl/rpn_token_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rpn_token_fifo
// Description : Circular token buffer. Pushes while full and pops while empty
//               are ignored. The head token is visible combinationally.
// Ports       : clk, rst (async, active-low)
//               push/push_tok   - write side
//               pop/head_tok    - read side (head valid when !empty)
//               count/full/empty- occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_token_fifo
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  token_t                     push_tok,
  input  logic                       pop,
  output token_t                     head_tok,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  token_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tok = mem_q[rd_ptr_q];
  assign count    = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (do_push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (do_pop ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tok;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rpn_token_sender.sv
`default_nettype none
// ============================================================================
// Module      : rpn_token_sender
// Description : Buffers user tokens and feeds them to an RPN calculator over a
//               four-phase strobe/ack handshake with an ack timeout; captures
//               calculator results over an independent four-phase handshake.
// Ports       : clk, rst (async, active-low)
//               tok_valid/tok_data/tok_is_op/tok_ready  - user token input
//               input_stb/input_data/is_input_operator/input_ack - to calc
//               output_stb/output_data/output_ack       - from calc
//               result_valid/result_data                - captured result
//               fifo_count, timeout_err, clr_err        - status/control
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_token_sender
  import rpn_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tok_valid,
  input  logic [3:0]                 tok_data,
  input  logic                       tok_is_op,
  output logic                       tok_ready,
  output logic                       input_stb,
  output logic [3:0]                 input_data,
  output logic                       is_input_operator,
  input  logic                       input_ack,
  input  logic                       output_stb,
  input  logic [3:0]                 output_data,
  output logic                       output_ack,
  output logic                       result_valid,
  output logic [3:0]                 result_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       timeout_err,
  input  logic                       clr_err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  token_t            head_tok;
  token_t            push_tok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              tmo_hit;

  tx_state_e         tx_state_q, tx_state_d;
  logic              stb_q, stb_d;
  token_t            tok_out_q, tok_out_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  rx_state_e         rx_state_q, rx_state_d;
  logic              oack_q, oack_d;
  logic              rvalid_q, rvalid_d;
  logic [3:0]        rdata_q, rdata_d;

  assign push_tok.is_op = tok_is_op;
  assign push_tok.data  = tok_data;

  rpn_token_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tok_valid),
    .push_tok (push_tok),
    .pop      (pop),
    .head_tok (head_tok),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tok_ready = !fifo_full;

  // Token side. An ack sampled on the same edge the timeout would expire
  // counts as a normal completion.
  always_comb begin
    tx_state_d = tx_state_q;
    stb_d      = stb_q;
    tok_out_d  = tok_out_q;
    tmo_cnt_d  = tmo_cnt_q;
    pop        = 1'b0;
    tmo_hit    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tok_out_d  = head_tok;
          stb_d      = 1'b1;
          tmo_cnt_d  = '0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (input_ack) begin
          stb_d      = 1'b0;
          tx_state_d = T_GAP;
        end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          stb_d      = 1'b0;
          tmo_hit    = 1'b1;
          tx_state_d = T_GAP;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
        end
      end
      T_GAP: begin
        if (!input_ack) begin
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        stb_d      = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
    // A fresh timeout beats a simultaneous clear.
    timeout_err_d = tmo_hit ? 1'b1 : (clr_err ? 1'b0 : timeout_err_q);
  end

  // Result side, independent of the token side.
  always_comb begin
    rx_state_d = rx_state_q;
    oack_d     = oack_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    if (rx_state_q == R_WAIT) begin
      if (output_stb) begin
        oack_d     = 1'b1;
        rdata_d    = output_data;
        rvalid_d   = 1'b1;
        rx_state_d = R_HOLD;
      end
    end else begin
      if (!output_stb) begin
        oack_d     = 1'b0;
        rx_state_d = R_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q    <= T_IDLE;
      stb_q         <= 1'b0;
      tok_out_q     <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      rx_state_q    <= R_WAIT;
      oack_q        <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      stb_q         <= stb_d;
      tok_out_q     <= tok_out_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      rx_state_q    <= rx_state_d;
      oack_q        <= oack_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign input_stb         = stb_q;
  assign input_data        = tok_out_q.data;
  assign is_input_operator = tok_out_q.is_op;
  assign timeout_err       = timeout_err_q;
  assign output_ack        = oack_q;
  assign result_valid      = rvalid_q;
  assign result_data       = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_token_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpn_token_sender
// Description : Directed bench for rpn_token_sender. Accepted tokens are
//               queued as expectations and matched against each token the
//               DUT strobes to the calculator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpn_token_sender;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid, tok_is_op, tok_ready;
  logic [3:0] tok_data;
  logic       input_stb, is_input_operator, input_ack;
  logic [3:0] input_data;
  logic       output_stb, output_ack, result_valid;
  logic [3:0] output_data, result_data;
  logic [3:0] fifo_count;
  logic       timeout_err, clr_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rise   = 0;
  int         n_rv     = 0;
  int         max_count = 0;
  logic       prev_stb = 1'b0;
  logic [4:0] held;
  token_t     exp_tok;
  token_t     q[$];

  rpn_token_sender #(
    .DEPTH       (8),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tok_valid         (tok_valid),
    .tok_data          (tok_data),
    .tok_is_op         (tok_is_op),
    .tok_ready         (tok_ready),
    .input_stb         (input_stb),
    .input_data        (input_data),
    .is_input_operator (is_input_operator),
    .input_ack         (input_ack),
    .output_stb        (output_stb),
    .output_data       (output_data),
    .output_ack        (output_ack),
    .result_valid      (result_valid),
    .result_data       (result_data),
    .fifo_count        (fifo_count),
    .timeout_err       (timeout_err),
    .clr_err           (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one token for exactly one edge; acc reports whether it was taken.
  task automatic push(input logic [3:0] d, input logic op, output bit acc);
    token_t t;
    tok_valid = 1'b1;
    tok_data  = d;
    tok_is_op = op;
    acc       = tok_ready;
    @(posedge clk);
    if (acc) begin
      t.data  = d;
      t.is_op = op;
      q.push_back(t);
    end
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  // Acks the current (or next) token dly cycles after it is first seen.
  task automatic serve(input int dly);
    int t = 0;
    while (!input_stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("serve_stb_seen", input_stb, 1);
    repeat (dly) @(negedge clk);
    input_ack = 1'b1;
    t = 0;
    while (input_stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("serve_stb_fall", input_stb, 0);
    input_ack = 1'b0;
  endtask

  // Scoreboard side: every rising strobe must match the oldest accepted token.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stb = 1'b0;
    end else begin
      if (input_stb && !prev_stb) begin
        n_rise++;
        check("sb_token_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_tok = q.pop_front();
          check("tok_data", input_data, exp_tok.data);
          check("tok_is_op", is_input_operator, exp_tok.is_op);
        end
        held = {is_input_operator, input_data};
      end else if (input_stb) begin
        check("tok_stable", {is_input_operator, input_data}, held);
      end
      prev_stb = input_stb;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (result_valid) n_rv++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cnt;
    int t;
    int rv_before;
    int rise_before;

    rst = 1'b0; tok_valid = 1'b0; tok_data = '0; tok_is_op = 1'b0;
    input_ack = 1'b0; output_stb = 1'b0; output_data = '0; clr_err = 1'b0;

    // Reset state, before any clock edge.
    #1;
    check("rst_input_stb", input_stb, 0);
    check("rst_output_ack", output_ack, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_data", result_data, 0);
    check("rst_input_data", input_data, 0);
    check("rst_is_op", is_input_operator, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_tok_ready", tok_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 3, 4, ADD back to back; strobe appears one edge after the first push.
    push(4'd3, 1'b0, acc);
    check("latency_not_yet", input_stb, 0);
    push(4'd4, 1'b0, acc);
    check("latency_stb", input_stb, 1);
    push(OP_ADD, 1'b1, acc);
    repeat (3) serve(2);
    repeat (3) @(negedge clk);
    check("seq_sb_empty", q.size(), 0);
    check("seq_fifo_empty", fifo_count, 0);
    check("seq_no_timeout", timeout_err, 0);

    // Fill: park the sender in its gap state by holding ack high after one
    // token, so nothing drains while nine tokens are offered.
    input_ack = 1'b1;
    push(4'd5, 1'b0, acc);
    repeat (4) @(negedge clk);
    check("prime_stb_done", input_stb, 0);
    for (int i = 0; i < 9; i++) begin
      push(4'(i + 6), i[0], acc);
      if (i == 8) check("full_reject", acc, 0);
      else        check("fill_accept", acc, 1);
    end
    check("full_count", fifo_count, 8);
    check("full_not_ready", tok_ready, 0);
    input_ack = 1'b0;
    repeat (8) serve(1);
    repeat (10) @(negedge clk);
    check("drain_sb_empty", q.size(), 0);
    check("drain_fifo_empty", fifo_count, 0);

    // Timeout: never ack token A; B must follow.
    push(4'hA, 1'b0, acc);
    push(4'hB, 1'b1, acc);
    t = 0;
    while (!input_stb && t < 50) begin @(negedge clk); t++; end
    cnt = 0;
    while (input_stb && cnt < 20) begin cnt++; @(negedge clk); end
    check("timeout_len", cnt, 4);
    check("timeout_err_set", timeout_err, 1);
    serve(1);
    check("timeout_err_sticky", timeout_err, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("timeout_err_clr", timeout_err, 0);

    // Clear on the same edge as a new timeout: set wins.
    push(4'hC, 1'b0, acc);
    t = 0;
    while (!input_stb && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("setwin_stb_high", input_stb, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("setwin_stb_drop", input_stb, 0);
    check("setwin_err", timeout_err, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("setwin_cleared", timeout_err, 0);
    repeat (3) @(negedge clk);

    // Result handshake in the middle of a token handshake.
    rv_before = n_rv;
    push(4'h2, 1'b1, acc);
    t = 0;
    while (!input_stb && t < 50) begin @(negedge clk); t++; end
    output_stb = 1'b1; output_data = 4'd7;
    @(negedge clk);
    check("rx_ack_set", output_ack, 1);
    check("rx_valid_pulse", result_valid, 1);
    check("rx_data", result_data, 7);
    check("rx_tok_stb_kept", input_stb, 1);
    @(negedge clk);
    check("rx_valid_once", result_valid, 0);
    check("rx_ack_hold", output_ack, 1);
    output_stb = 1'b0; output_data = 4'd0;
    input_ack = 1'b1;
    @(negedge clk);
    check("rx_ack_drop", output_ack, 0);
    check("rx_tok_acked", input_stb, 0);
    check("rx_data_held", result_data, 7);
    input_ack = 1'b0;
    check("rx_pulse_count", n_rv - rv_before, 1);
    check("rx_no_timeout", timeout_err, 0);
    repeat (3) @(negedge clk);

    // Reset mid-handshake with three tokens queued.
    push(4'd1, 1'b0, acc);
    push(4'd2, 1'b0, acc);
    push(4'd3, 1'b1, acc);
    push(4'd4, 1'b0, acc);
    check("mid_stb_high", input_stb, 1);
    check("mid_count", fifo_count, 3);
    rst = 1'b0;
    #1;
    check("async_rst_stb", input_stb, 0);
    check("async_rst_count", fifo_count, 0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    rise_before = n_rise;
    repeat (10) @(negedge clk);
    check("no_replay", n_rise - rise_before, 0);
    check("post_rst_count", fifo_count, 0);
    push(4'hD, 1'b0, acc);
    serve(1);
    repeat (3) @(negedge clk);
    check("post_rst_sb_empty", q.size(), 0);
    check("count_max", max_count <= 8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
